// File: rtl/encoder_period_meas.sv
// Encoder period measurement: counts selected-channel rising edges and clocks over SYNC_NUM sync periods.
// Optional quadrature direction counting is enabled with the ENC_QUAD_DIR_EN macro.
module encoder_period_meas #(
  parameter int unsigned CH_NUM   = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PCNT_W   = 16,
  parameter int unsigned SYNC_NUM = 8
) (
  input  logic              clk,
  input  logic              mcu_n_rst,
  input  logic [CH_NUM-1:0] ch_sgn_in,
`ifdef ENC_QUAD_DIR_EN
  input  logic [CH_NUM-1:0] ch_b_in,
`endif
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              ch_sync,
  input  logic              mcu_start,
  output logic              mcu_end,
  output logic              meas_busy,
  output logic              ovf,
  input  logic [2:0]        mcu_data_sel,
  output logic [7:0]        mcu_data,
  output logic [PCNT_W-1:0] pulse_cnt_out,
  output logic [CNT_W-1:0]  clk_cnt_out
);

  localparam int unsigned SCNT_W = 8;
`ifdef ENC_QUAD_DIR_EN
  localparam logic              QUAD_FLAG = 1'b1;
  localparam logic [PCNT_W-1:0] PCNT_MAX  = {1'b0, {(PCNT_W-1){1'b1}}};
  localparam logic [PCNT_W-1:0] PCNT_MIN  = {1'b1, {(PCNT_W-1){1'b0}}};
`else
  localparam logic              QUAD_FLAG = 1'b0;
  localparam logic [PCNT_W-1:0] PCNT_MAX  = {PCNT_W{1'b1}};
`endif
  localparam logic [SCNT_W-1:0] LAST_SYNC = SCNT_W'(SYNC_NUM - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [2:0]        sync_sr, start_sr, a_sr;
  logic              sync_p, start_p, a_rise, term;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_d;
  logic [PCNT_W-1:0] pulse_cnt, pulse_cnt_d;
  logic [SCNT_W-1:0] sync_cnt, sync_cnt_d;
  logic              ovf_d;
  logic [31:0]       clk_ext;
  logic [15:0]       pulse_ext;
`ifdef ENC_QUAD_DIR_EN
  logic [1:0]        b_sr;
`endif

  // [0],[1] form the 2-FF synchroniser, [2] is the edge register
  assign sync_p  = sync_sr[1]  & ~sync_sr[2];
  assign start_p = start_sr[1] & ~start_sr[2];
  assign a_rise  = a_sr[1]     & ~a_sr[2];
  assign term    = (state == MEAS) && sync_p && (sync_cnt == LAST_SYNC);

  // Next state, counters and saturation flag
  always_comb begin
    state_d     = state;
    clk_cnt_d   = clk_cnt;
    pulse_cnt_d = pulse_cnt;
    sync_cnt_d  = sync_cnt;
    ovf_d       = ovf;
    if (start_p) begin
      state_d     = ARM;
      clk_cnt_d   = '0;
      pulse_cnt_d = '0;
      sync_cnt_d  = '0;
      ovf_d       = 1'b0;
    end else begin
      case (state)
        ARM: if (sync_p) begin
          state_d     = MEAS;
          clk_cnt_d   = '0;
          pulse_cnt_d = '0;
          sync_cnt_d  = '0;
        end
        MEAS: begin
          if (clk_cnt == {CNT_W{1'b1}}) ovf_d = 1'b1;
          else                          clk_cnt_d = clk_cnt + CNT_W'(1);
          if (a_rise) begin
`ifdef ENC_QUAD_DIR_EN
            if (b_sr[1]) begin
              if (pulse_cnt == PCNT_MIN) ovf_d = 1'b1;
              else                       pulse_cnt_d = pulse_cnt - PCNT_W'(1);
            end else begin
              if (pulse_cnt == PCNT_MAX) ovf_d = 1'b1;
              else                       pulse_cnt_d = pulse_cnt + PCNT_W'(1);
            end
`else
            if (pulse_cnt == PCNT_MAX) ovf_d = 1'b1;
            else                       pulse_cnt_d = pulse_cnt + PCNT_W'(1);
`endif
          end
          if (sync_p) sync_cnt_d = sync_cnt + SCNT_W'(1);
          if (term)   state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // State, synchronisers, counters and registered outputs
  always_ff @(posedge clk or negedge mcu_n_rst) begin
    if (!mcu_n_rst) begin
      state         <= IDLE;
      sel_q         <= '0;
      sync_sr       <= '0;
      start_sr      <= '0;
      a_sr          <= '0;
      clk_cnt       <= '0;
      pulse_cnt     <= '0;
      sync_cnt      <= '0;
      ovf           <= 1'b0;
      mcu_end       <= 1'b0;
      meas_busy     <= 1'b0;
      clk_cnt_out   <= '0;
      pulse_cnt_out <= '0;
`ifdef ENC_QUAD_DIR_EN
      b_sr          <= '0;
`endif
    end else begin
      state     <= state_d;
      sync_sr   <= {sync_sr[1:0], ch_sync};
      start_sr  <= {start_sr[1:0], mcu_start};
      a_sr      <= {a_sr[1:0], ch_sgn_in[sel_q]};
`ifdef ENC_QUAD_DIR_EN
      b_sr      <= {b_sr[0], ch_b_in[sel_q]};
`endif
      clk_cnt   <= clk_cnt_d;
      pulse_cnt <= pulse_cnt_d;
      sync_cnt  <= sync_cnt_d;
      ovf       <= ovf_d;
      mcu_end   <= (state_d == DONE);
      meas_busy <= (state_d == ARM) || (state_d == MEAS);
      if (start_p) sel_q <= (32'(ch_sel) < CH_NUM) ? ch_sel : '0;
      if (term) begin
        clk_cnt_out   <= clk_cnt_d;
        pulse_cnt_out <= pulse_cnt_d;
      end
    end
  end

  assign clk_ext   = 32'(clk_cnt_out);
  assign pulse_ext = 16'(pulse_cnt_out);

  // Byte-wise MCU readback mux
  always_comb begin
    mcu_data = 8'h00;
    case (mcu_data_sel)
      3'd0: mcu_data = clk_ext[7:0];
      3'd1: mcu_data = clk_ext[15:8];
      3'd2: mcu_data = clk_ext[23:16];
      3'd3: mcu_data = clk_ext[31:24];
      3'd4: mcu_data = pulse_ext[7:0];
      3'd5: mcu_data = pulse_ext[15:8];
      3'd6: mcu_data = 8'(SYNC_NUM);
      default: mcu_data = {4'b0000, ovf, mcu_end, meas_busy, QUAD_FLAG};
    endcase
  end

endmodule
